axi_lite_reg_slave: RTL and testbench

// AXI4-Lite responder at the slave end of the two-master/two-slave interconnect. Terminates the AW/W/B write
// and AR/R read channels into a small register bank mapped at BASE_ADDR. Reports SLVERR for out-of-range

---
 rtl/axi_lite_reg_slave.sv | 200 ++++++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register-bank responder: independent write (AW/W/B) and read (AR/R) engines
// over NUM_REGS registers at BASE_ADDR, with SLVERR for addresses outside the bank.
module axi_lite_reg_slave #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hAA,
    parameter int                NUM_REGS  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready
);
    localparam int              STRB_W      = DATA_W / 8;
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;
    localparam logic [ADDR_W:0] NUM_REGS_L  = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_ADDR, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    // Offset arithmetic is modulo 2^ADDR_W, so addresses below BASE_ADDR decode as huge indices.
    function automatic logic addr_hit(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] idx;
        idx = addr - BASE_ADDR;
        return ({1'b0, idx} < NUM_REGS_L);
    endfunction

    wstate_t             wstate_r;
    rstate_t             rstate_r;
    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic [ADDR_W-1:0]   awaddr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   wstrb_r;

    logic                aw_hs_s;
    logic                w_hs_s;
    logic                commit_s;
    logic [ADDR_W-1:0]   cm_addr_s;
    logic [ADDR_W-1:0]   cm_idx_s;
    logic [DATA_W-1:0]   cm_data_s;
    logic [STRB_W-1:0]   cm_strb_s;
    logic [1:0]          cm_resp_s;
    logic [ADDR_W-1:0]   rd_idx_s;
    logic [DATA_W-1:0]   rd_data_s;

    // Select the address/data pair that completes on this edge (one half may be latched).
    always_comb begin
        aw_hs_s   = awvalid & awready;
        w_hs_s    = wvalid & wready;
        cm_addr_s = (wstate_r == W_DATA) ? awaddr_r : awaddr;
        cm_data_s = (wstate_r == W_ADDR) ? wdata_r : wdata;
        cm_strb_s = (wstate_r == W_ADDR) ? wstrb_r : wstrb;
        cm_idx_s  = cm_addr_s - BASE_ADDR;
        cm_resp_s = addr_hit(cm_addr_s) ? RESP_OKAY : RESP_SLVERR;
        commit_s  = 1'b0;
        case (wstate_r)
            W_IDLE:  commit_s = aw_hs_s & w_hs_s;
            W_DATA:  commit_s = w_hs_s;
            W_ADDR:  commit_s = aw_hs_s;
            default: commit_s = 1'b0;
        endcase
    end

    // Read mux; out-of-range indices match no register and return zero.
    always_comb begin
        rd_idx_s  = araddr - BASE_ADDR;
        rd_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = (rd_idx_s == ADDR_W'(i)) ? regs_r[i] : rd_data_s;
        end
    end

    // Write engine: AW/W collection, byte-lane commit and B response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_r <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            awaddr_r <= {ADDR_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
            wstrb_r  <= {STRB_W{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (commit_s) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if ((cm_idx_s == ADDR_W'(i)) && cm_strb_s[b]) begin
                            regs_r[i][8*b +: 8] <= cm_data_s[8*b +: 8];
                        end
                    end
                end
            end
            case (wstate_r)
                W_IDLE: begin
                    if (commit_s) begin
                        bvalid   <= 1'b1;
                        bresp    <= cm_resp_s;
                        awready  <= 1'b0;
                        wready   <= 1'b0;
                        wstate_r <= W_RESP;
                    end else if (aw_hs_s) begin
                        awaddr_r <= awaddr;
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        wstate_r <= W_DATA;
                    end else if (w_hs_s) begin
                        wdata_r  <= wdata;
                        wstrb_r  <= wstrb;
                        awready  <= 1'b1;
                        wready   <= 1'b0;
                        wstate_r <= W_ADDR;
                    end else begin
                        awready  <= 1'b1;
                        wready   <= 1'b1;
                    end
                end
                W_DATA, W_ADDR: begin
                    if (commit_s) begin
                        bvalid   <= 1'b1;
                        bresp    <= cm_resp_s;
                        awready  <= 1'b0;
                        wready   <= 1'b0;
                        wstate_r <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wready   <= 1'b1;
                        wstate_r <= W_IDLE;
                    end
                end
                default: begin
                    bvalid   <= 1'b0;
                    awready  <= 1'b0;
                    wready   <= 1'b0;
                    wstate_r <= W_IDLE;
                end
            endcase
        end
    end

    // Read engine: capture on AR handshake, hold R until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_r <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
            rdata    <= {DATA_W{1'b0}};
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    if (arvalid & arready) begin
                        rdata    <= rd_data_s;
                        rresp    <= addr_hit(araddr) ? RESP_OKAY : RESP_SLVERR;
                        arready  <= 1'b0;
                        rvalid   <= 1'b1;
                        rstate_r <= R_DATA;
                    end else begin
                        arready  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid   <= 1'b0;
                        arready  <= 1'b1;
                        rstate_r <= R_IDLE;
                    end
                end
                default: begin
                    rvalid   <= 1'b0;
                    arready  <= 1'b0;
                    rstate_r <= R_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed scenarios plus randomized
// transactions checked against an array model of the register bank.
module tb_axi_lite_reg_slave;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] awaddr = 8'h00;
    logic       awvalid = 1'b0;
    logic       awready;
    logic [7:0] wdata = 8'h00;
    logic [0:0] wstrb = 1'b0;
    logic       wvalid = 1'b0;
    logic       wready;
    logic [1:0] bresp;
    logic       bvalid;
    logic       bready = 1'b0;
    logic [7:0] araddr = 8'h00;
    logic       arvalid = 1'b0;
    logic       arready;
    logic [7:0] rdata;
    logic [1:0] rresp;
    logic       rvalid;
    logic       rready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] model [4];

    axi_lite_reg_slave #(.DATA_W(8), .ADDR_W(8), .BASE_ADDR(8'hAA), .NUM_REGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_bank(input logic [7:0] a);
        int off;
        off = (int'(a) - 170 + 256) % 256;
        return off < 4;
    endfunction

    function automatic int bank_index(input logic [7:0] a);
        return (int'(a) - 170 + 256) % 256;
    endfunction

    function automatic logic [7:0] expect_rd(input logic [7:0] a);
        if (in_bank(a)) return model[bank_index(a)];
        return 8'h00;
    endfunction

    function automatic logic [1:0] expect_resp(input logic [7:0] a);
        return in_bank(a) ? 2'b00 : 2'b10;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [7:0] data, input logic strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        bit aw_fire;
        bit w_fire;
        int cyc = 0;
        logic [1:0] exp_resp;
        exp_resp = expect_resp(addr);
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 30) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            if (aw_done != w_done) begin
                checks++;
                if ({awready, wready} !== {!aw_done, !w_done})
                    $display("FAIL half_done_ready: awready/wready=%b%b required %b%b",
                             awready, wready, !aw_done, !w_done);
                if ({awready, wready} !== {!aw_done, !w_done}) errors++;
            end
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick();
            cyc++;
            if (aw_fire) aw_done = 1'b1;
            if (w_fire) w_done = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checks++;
        if (!(aw_done && w_done)) begin
            errors++;
            $display("FAIL write_handshake_timeout: aw_done=%0b w_done=%0b required 1 1", aw_done, w_done);
            return;
        end
        checks++;
        if (bvalid !== 1'b1 || bresp !== exp_resp) begin
            errors++;
            $display("FAIL write_resp addr=%h: bvalid=%b bresp=%b required 1 %b", addr, bvalid, bresp, exp_resp);
        end
        for (int i = 0; i < b_dly; i++) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== exp_resp || awready !== 1'b0 || wready !== 1'b0) begin
                errors++;
                $display("FAIL b_backpressure: bvalid=%b bresp=%b awready=%b wready=%b required 1 %b 0 0",
                         bvalid, bresp, awready, wready, exp_resp);
            end
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL b_release: bvalid=%b awready=%b wready=%b required 0 1 1", bvalid, awready, wready);
        end
        if (in_bank(addr) && strb) model[bank_index(addr)] = data;
    endtask

    task automatic axi_read(input logic [7:0] addr, input int ar_dly, input int r_dly);
        bit ar_fire = 1'b0;
        int cyc = 0;
        logic [7:0] exp_data;
        logic [1:0] exp_resp;
        exp_data = expect_rd(addr);
        exp_resp = expect_resp(addr);
        araddr = addr;
        while (!ar_fire && cyc < 30) begin
            arvalid = (cyc >= ar_dly);
            ar_fire = arvalid && arready;
            tick();
            cyc++;
        end
        arvalid = 1'b0;
        checks++;
        if (!ar_fire) begin
            errors++;
            $display("FAIL read_handshake_timeout: arready never seen, required 1");
            return;
        end
        for (int i = 0; i <= r_dly; i++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== exp_data || rresp !== exp_resp || arready !== 1'b0) begin
                errors++;
                $display("FAIL read_resp addr=%h cyc=%0d: rvalid=%b rdata=%h rresp=%b arready=%b required 1 %h %b 0",
                         addr, i, rvalid, rdata, rresp, arready, exp_data, exp_resp);
            end
            if (i < r_dly) tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL r_release: rvalid=%b arready=%b required 0 1", rvalid, arready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata} !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs: %b required all zero",
                     {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++;
            $display("FAIL ready_before_edge: %b required 000", {awready, wready, arready});
        end
        tick();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_release: %b required 111", {awready, wready, arready});
        end
        clear_model();
    endtask

    task automatic test_basic();
        axi_write(8'hAB, 8'h5A, 1'b1, 0, 0, 0);
        axi_read(8'hAB, 0, 0);
    endtask

    task automatic test_split_order();
        axi_write(8'hAC, 8'h3C, 1'b1, 0, 3, 0);
        axi_write(8'hAD, 8'hC3, 1'b1, 3, 0, 0);
        axi_read(8'hAC, 0, 0);
        axi_read(8'hAD, 0, 0);
    endtask

    task automatic test_out_of_range();
        axi_write(8'hBF, 8'hFF, 1'b1, 0, 0, 0);
        axi_read(8'hBF, 0, 0);
        axi_write(8'hA9, 8'hEE, 1'b1, 1, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(8'hAA + 8'(i), 0, 0);
    endtask

    task automatic test_strobe_zero();
        axi_write(8'hAB, 8'h77, 1'b0, 0, 0, 0);
        axi_read(8'hAB, 0, 0);
    endtask

    task automatic test_backpressure();
        axi_write(8'hAA, 8'h96, 1'b1, 0, 0, 5);
        axi_write(8'hBF, 8'h01, 1'b1, 0, 0, 5);
        axi_read(8'hAA, 0, 5);
        axi_read(8'hBF, 0, 5);
    endtask

    task automatic test_collision();
        axi_write(8'hAA, 8'h11, 1'b1, 0, 0, 0);
        awaddr = 8'hAA; wdata = 8'h22; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'hAA; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 8'h11 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL collision: bvalid=%b rvalid=%b rdata=%h bresp=%b required 1 1 11 00",
                     bvalid, rvalid, rdata, bresp);
        end
        model[0] = 8'h22;
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        axi_read(8'hAA, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            logic [7:0] a;
            a = 8'hA8 + 8'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 0)
                axi_write(a, 8'($urandom), 1'($urandom_range(0, 3) != 0),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_write();
        awaddr = 8'hAC; wdata = 8'hA5; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL midwrite_bvalid: %b required 1", bvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bvalid, awready, wready, arready} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: bvalid/awready/wready/arready=%b required 0000",
                     {bvalid, awready, wready, arready});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if ({bvalid, awready, wready, arready} !== 4'b0111) begin
            errors++;
            $display("FAIL post_reset_ready: %b required 0111", {bvalid, awready, wready, arready});
        end
        clear_model();
        for (int i = 0; i < 4; i++) axi_read(8'hAA + 8'(i), 0, 0);
    endtask

    initial begin
        clear_model();
        test_reset();
        test_basic();
        test_split_order();
        test_out_of_range();
        test_strobe_zero();
        test_backpressure();
        test_collision();
        test_random();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
